// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: dispenser states, coin values,
// one-hot ejector codes and the 6-bit change value width.
package vending_pkg;

    localparam int VALUE_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EJECT,
        ST_GAP,
        ST_FINISH,
        ST_FAULT
    } disp_state_t;

    localparam logic [VALUE_W-1:0] COIN_10 = 6'd10;
    localparam logic [VALUE_W-1:0] COIN_5  = 6'd5;
    localparam logic [VALUE_W-1:0] COIN_2  = 6'd2;
    localparam logic [VALUE_W-1:0] COIN_1  = 6'd1;

    localparam logic [3:0] EJ_NONE = 4'b0000;
    localparam logic [3:0] EJ_10   = 4'b1000;
    localparam logic [3:0] EJ_5    = 4'b0100;
    localparam logic [3:0] EJ_2    = 4'b0010;
    localparam logic [3:0] EJ_1    = 4'b0001;

    // Largest possible result is 3*(10+5+2+1) = 54, so 6 bits never overflow.
    function automatic logic [VALUE_W-1:0] change_value(input logic [1:0] n10,
                                                        input logic [1:0] n5,
                                                        input logic [1:0] n2,
                                                        input logic [1:0] n1);
        return VALUE_W'(n10) * COIN_10 + VALUE_W'(n5) * COIN_5
             + VALUE_W'(n2) * COIN_2 + VALUE_W'(n1) * COIN_1;
    endfunction

endpackage

// File: rtl/change_dispenser_coin_picker.sv
// Priority select of the largest denomination still owed: one-hot ejector
// code plus that coin's unit value (zero when nothing is owed).
module coin_picker
    import vending_pkg::*;
(
    input  logic [1:0]         cnt_10,
    input  logic [1:0]         cnt_5,
    input  logic [1:0]         cnt_2,
    input  logic [1:0]         cnt_1,
    output logic [3:0]         code,
    output logic [VALUE_W-1:0] value
);

    always_comb begin
        code  = EJ_NONE;
        value = '0;
        if (cnt_10 != 2'd0) begin
            code  = EJ_10;
            value = COIN_10;
        end else if (cnt_5 != 2'd0) begin
            code  = EJ_5;
            value = COIN_5;
        end else if (cnt_2 != 2'd0) begin
            code  = EJ_2;
            value = COIN_2;
        end else if (cnt_1 != 2'd0) begin
            code  = EJ_1;
            value = COIN_1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Coin ejector sequencer: latches change counts on load and releases one coin
// per ack, largest first. CHANGE_DISP_TIMEOUT_EN adds the ack timeout / fault.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [1:0]         c10,
    input  logic [1:0]         c5,
    input  logic [1:0]         c2,
    input  logic [1:0]         c1,
    input  logic               coin_ack,
    output logic [3:0]         eject,
    output logic               busy,
    output logic               done,
    output logic [VALUE_W-1:0] remaining,
    output logic               fault
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    disp_state_t        state;
    disp_state_t        state_next;
    logic [1:0]         cnt_10;
    logic [1:0]         cnt_5;
    logic [1:0]         cnt_2;
    logic [1:0]         cnt_1;
    logic [3:0]         gap_cnt;
    logic [3:0]         pick_code;
    logic [VALUE_W-1:0] pick_value;
    logic [3:0]         coin_total;
    logic               more_coins;
    logic               timed_out;

    coin_picker u_picker (
        .cnt_10 (cnt_10),
        .cnt_5  (cnt_5),
        .cnt_2  (cnt_2),
        .cnt_1  (cnt_1),
        .code   (pick_code),
        .value  (pick_value)
    );

    // Coins left after the one currently being ejected decides GAP vs FINISH.
    assign coin_total = {2'b00, cnt_10} + {2'b00, cnt_5} + {2'b00, cnt_2} + {2'b00, cnt_1};
    assign more_coins = coin_total > 4'd1;

`ifdef CHANGE_DISP_TIMEOUT_EN
    localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);
    logic [7:0] wait_cnt;

    // Counts EJECT cycles without an ack; zero in every other state, so it
    // is already clear whenever EJECT is entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state != ST_EJECT) begin
            wait_cnt <= '0;
        end else if (!coin_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timed_out = (wait_cnt == ACK_LAST);
    assign fault     = (state == ST_FAULT);
`else
    assign timed_out = 1'b0;
    // ACK_TIMEOUT is never negative, so this is a constant low.
    assign fault     = (ACK_TIMEOUT < 0);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    state_next = ((c10 | c5 | c2 | c1) != 2'b00) ? ST_EJECT : ST_FINISH;
                end
            end
            ST_EJECT: begin
                if (coin_ack) begin
                    state_next = more_coins ? ST_GAP : ST_FINISH;
                end else if (timed_out) begin
                    state_next = ST_FAULT;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = ST_EJECT;
                end
            end
            ST_FINISH: state_next = ST_IDLE;
            ST_FAULT:  state_next = ST_FAULT;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Coin counters, remaining value and gap timer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_10    <= '0;
            cnt_5     <= '0;
            cnt_2     <= '0;
            cnt_1     <= '0;
            remaining <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        cnt_10    <= c10;
                        cnt_5     <= c5;
                        cnt_2     <= c2;
                        cnt_1     <= c1;
                        remaining <= change_value(c10, c5, c2, c1);
                    end
                end
                ST_EJECT: begin
                    gap_cnt <= '0;
                    if (coin_ack) begin
                        remaining <= remaining - pick_value;
                        case (pick_code)
                            EJ_10:   cnt_10 <= cnt_10 - 2'd1;
                            EJ_5:    cnt_5  <= cnt_5 - 2'd1;
                            EJ_2:    cnt_2  <= cnt_2 - 2'd1;
                            EJ_1:    cnt_1  <= cnt_1 - 2'd1;
                            default: ;
                        endcase
                    end
                end
                ST_GAP:  gap_cnt <= gap_cnt + 4'd1;
                default: ;
            endcase
        end
    end

    assign eject = (state == ST_EJECT) ? pick_code : EJ_NONE;
    assign busy  = (state == ST_EJECT) || (state == ST_GAP) || (state == ST_FINISH);
    assign done  = (state == ST_FINISH);

endmodule

// File: tb/tb_change_dispenser.sv
// Randomised bench for change_dispenser: a queue-of-coins model predicts the
// outputs every cycle, with literal checks from the directed scenarios.
module tb_change_dispenser;

    localparam int GAP = 2;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       load     = 1'b0;
    logic [1:0] c10      = '0;
    logic [1:0] c5       = '0;
    logic [1:0] c2       = '0;
    logic [1:0] c1       = '0;
    logic       coin_ack = 1'b0;
    logic [3:0] eject;
    logic       busy;
    logic       done;
    logic [5:0] remaining;
    logic       fault;

    change_dispenser #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .c10       (c10),
        .c5        (c5),
        .c2        (c2),
        .c1        (c1),
        .coin_ack  (coin_ack),
        .eject     (eject),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .fault     (fault)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int ack_mode    = 0;
    int done_cnt    = 0;
    logic [3:0] seen_q[$];
    int         seen_cyc[$];

    // Model: the coins still owed as a list of values, plus gap/done flags.
    int coin_q[$];
    int gap_left = 0;
    bit m_busy   = 1'b0;
    bit m_done   = 1'b0;

    function automatic int model_remaining();
        int s = 0;
        foreach (coin_q[i]) s += coin_q[i];
        return s;
    endfunction

    function automatic logic [3:0] model_eject();
        if (!m_busy || m_done || gap_left != 0 || coin_q.size() == 0) return 4'b0000;
        case (coin_q[0])
            10:      return 4'b1000;
            5:       return 4'b0100;
            2:       return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            coin_q.delete();
            gap_left = 0;
            m_busy   = 1'b0;
            m_done   = 1'b0;
        end else begin
            cycle++;
            if (!m_busy) begin
                if (load) begin
                    for (int i = 0; i < int'(c10); i++) coin_q.push_back(10);
                    for (int i = 0; i < int'(c5); i++)  coin_q.push_back(5);
                    for (int i = 0; i < int'(c2); i++)  coin_q.push_back(2);
                    for (int i = 0; i < int'(c1); i++)  coin_q.push_back(1);
                    m_busy   = 1'b1;
                    m_done   = (coin_q.size() == 0);
                    gap_left = 0;
                end
            end else if (m_done) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end else if (gap_left > 0) begin
                gap_left--;
            end else if (coin_ack) begin
                void'(coin_q.pop_front());
                if (coin_q.size() == 0) m_done = 1'b1;
                else gap_left = GAP;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clock);
        if (reset) begin
            vectors++;
            if (eject !== model_eject() || busy !== m_busy || done !== m_done ||
                int'(remaining) != model_remaining() || fault !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL cycle_check @%0d: eject=%b busy=%b done=%b rem=%0d fault=%b, required eject=%b busy=%b done=%b rem=%0d fault=0",
                         cycle, eject, busy, done, remaining, fault,
                         model_eject(), m_busy, m_done, model_remaining());
            end
        end
    end

    // Ejector responder: 0 never acks, 1 ack tied high, 2 ack one cycle after eject, 3 random.
    initial begin
        int age = 0;
        forever begin
            @(posedge clock);
            #2;
            age = (eject != 4'b0000) ? age + 1 : 0;
            case (ack_mode)
                1:       coin_ack = 1'b1;
                2:       coin_ack = (age >= 2);
                3:       coin_ack = ($urandom_range(0, 2) == 0);
                default: coin_ack = 1'b0;
            endcase
        end
    end

    // Logs each rising eject code with its cycle, and counts done pulses.
    initial begin
        logic [3:0] prev = 4'b0000;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev = 4'b0000;
            end else begin
                if (eject != 4'b0000 && prev == 4'b0000) begin
                    seen_q.push_back(eject);
                    seen_cyc.push_back(cycle);
                end
                if (done) done_cnt++;
                prev = eject;
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] n10, input logic [1:0] n5,
                                 input logic [1:0] n2, input logic [1:0] n1);
        @(posedge clock);
        #2;
        c10  = n10;
        c5   = n5;
        c2   = n2;
        c1   = n1;
        load = 1'b1;
        @(posedge clock);
        #2;
        load = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((m_busy || busy) && n < budget) begin
            @(posedge clock);
            #3;
            n++;
        end
        checkOutput("idle_within_budget", int'(busy), 0);
    endtask

    task automatic clearLog();
        seen_q.delete();
        seen_cyc.delete();
        done_cnt = 0;
    endtask

    initial begin
        int exp_t1[4] = '{8, 2, 2, 1};
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int exp_t1[4] = '{8, 2, 2, 1};
        #17 reset = 1'b1;
        #1;
        checkOutput("reset_eject", int'(eject), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_remaining", int'(remaining), 0);
        checkOutput("reset_fault", int'(fault), 0);

        // 10 + 2 + 2 + 1, acked one cycle after each eject
        ack_mode = 2;
        clearLog();
        applyStimulus(2'd1, 2'd0, 2'd2, 2'd1);
        checkOutput("t1_remaining_after_load", int'(remaining), 15);
        checkOutput("t1_model_remaining", model_remaining(), 15);
        checkOutput("t1_busy_after_load", int'(busy), 1);
        checkOutput("t1_first_eject", int'(eject), 8);
        waitIdle(200);
        checkOutput("t1_eject_count", seen_q.size(), 4);
        for (int i = 0; i < 4; i++)
            checkOutput("t1_eject_seq", (i < seen_q.size()) ? int'(seen_q[i]) : -1, exp_t1[i]);
        checkOutput("t1_done_pulses", done_cnt, 1);
        checkOutput("t1_remaining_end", int'(remaining), 0);

        // All-zero load: immediate done, no eject
        ack_mode = 0;
        clearLog();
        applyStimulus(2'd0, 2'd0, 2'd0, 2'd0);
        checkOutput("t2_done", int'(done), 1);
        checkOutput("t2_eject", int'(eject), 0);
        checkOutput("t2_remaining", int'(remaining), 0);
        @(posedge clock);
        #2;
        checkOutput("t2_done_cleared", int'(done), 0);
        checkOutput("t2_busy_cleared", int'(busy), 0);
        checkOutput("t2_no_ejects", seen_q.size(), 0);

        // Full load with ack tied high: 12 coins, GAP+1 cycles apart
        ack_mode = 1;
        clearLog();
        applyStimulus(2'd3, 2'd3, 2'd3, 2'd3);
        checkOutput("t3_remaining_after_load", int'(remaining), 54);
        waitIdle(300);
        checkOutput("t3_eject_count", seen_q.size(), 12);
        for (int i = 1; i < seen_cyc.size(); i++)
            checkOutput("t3_eject_spacing", seen_cyc[i] - seen_cyc[i-1], GAP + 1);
        checkOutput("t3_remaining_end", int'(remaining), 0);

        // A second load while dispensing is ignored
        ack_mode = 3;
        clearLog();
        applyStimulus(2'd0, 2'd1, 2'd0, 2'd1);
        applyStimulus(2'd0, 2'd0, 2'd0, 2'd3);
        waitIdle(300);
        checkOutput("t4_eject_count", seen_q.size(), 2);

        // Asynchronous reset in the middle of an eject
        ack_mode = 0;
        applyStimulus(2'd2, 2'd0, 2'd0, 2'd0);
        repeat (2) @(posedge clock);
        #3;
        checkOutput("t5_eject_before_reset", int'(eject), 8);
        reset = 1'b0;
        #1;
        checkOutput("t5_eject_in_reset", int'(eject), 0);
        checkOutput("t5_busy_in_reset", int'(busy), 0);
        checkOutput("t5_remaining_in_reset", int'(remaining), 0);
        @(negedge clock);
        #1 reset = 1'b1;
        ack_mode = 2;
        clearLog();
        applyStimulus(2'd0, 2'd1, 2'd1, 2'd0);
        checkOutput("t5_remaining_reload", int'(remaining), 7);
        waitIdle(200);
        checkOutput("t5_eject_count", seen_q.size(), 2);
        checkOutput("t5_eject_first", (seen_q.size() > 0) ? int'(seen_q[0]) : -1, 4);
        checkOutput("t5_eject_second", (seen_q.size() > 1) ? int'(seen_q[1]) : -1, 2);

        // Random loads, random ack behaviour, occasional stray loads while busy
        for (int t = 0; t < 40; t++) begin
            ack_mode = $urandom_range(1, 3);
            applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1)
                applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            waitIdle(600);
        end

        ack_mode = 0;
        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the vending machine: consumes the per-denomination change counts (`c10`, `c5`, `c2`, `c1`, 2 bits each) that the vending machine produces with a vend. It latches them on a load strobe and drives the coin-ejector mechanism one coin at a time, largest denomination first, with a request/acknowledge handshake per coin. It reports busy/done status and the remaining change value, and can flag an unresponsive ejector.

## Interface
Parameters:
- `GAP_CYCLES`, default 2: idle cycles between consecutive ejections (1..15).
- `ACK_TIMEOUT`, default 64: cycles an eject request may wait for `coin_ack` before fault; only used with timeout enabled (2..255).

Ports:
- `clock` input 1: single clock, rising edge.
- `reset` input 1: reset is asynchronous and active-low. One clock; all state clears immediately on assertion.
- `load` input 1: one-cycle strobe; capture the change counts.
- `c10`, `c5`, `c2`, `c1` input 2 each: coin counts to dispense (0..3 each).
- `coin_ack` input 1: ejector reports the requested coin was released.
- `eject` output 4: one-hot coin request {10,5,2,1} = bits [3:0]; held until acknowledged.
- `busy` output 1: high from the cycle after `load` until `done`.
- `done` output 1: one-cycle pulse when all latched coins are out.
- `remaining` output 6: value still to dispense, in units (0..54).
- `fault` output 1: ejector timeout, sticky.

## Operation
- Reset values: `eject`=0, `busy`=0, `done`=0, `remaining`=0, `fault`=0, state IDLE, all counters 0.
- States: IDLE, EJECT, GAP, FINISH, FAULT.
- IDLE:
  - `load`=1 latches the four counts into 2-bit down-counters.
  - `remaining` = 10·c10 + 5·c5 + 2·c2 + c1, computed in 6 bits with no overflow (maximum 54).
  - If any count is non-zero, go to EJECT; otherwise go to FINISH.
- EJECT:
  - `eject` is one-hot on the highest denomination with a non-zero count.
  - `coin_ack` sampled high: decrement that counter, subtract its value from `remaining`, clear `eject`.
  - Then go to GAP if coins remain, or to FINISH if none remain.
- GAP: wait `GAP_CYCLES` cycles with `eject`=0, then go to EJECT.
- FINISH: `done`=1 for one cycle, `busy`=0 on exit, return to IDLE.
- FAULT: `eject`=0, `busy`=0, `fault`=1. The block leaves FAULT only by reset.
- `load` outside IDLE is ignored; counts are not merged.
- `coin_ack` outside EJECT is ignored.
- A reset during any state aborts dispensing; the remaining coins are discarded.

## Timing
- `load` sampled at edge k:
  - `busy`=1 and `remaining` valid after edge k.
  - `eject` asserted after edge k (registered, state EJECT).
- `coin_ack` sampled high at edge m:
  - `eject` drops and `remaining` updates after edge m.
  - The next `eject` rises after edge m+`GAP_CYCLES`.
- Last ack at edge m: `done`=1 during cycle m→m+1; `busy` low after edge m+1.
- All-zero load at edge k: `done` pulses after edge k; no `eject` is issued.
- `coin_ack` held high continuously: one coin per EJECT visit, so coins are spaced `GAP_CYCLES`+1 cycles apart.

## Configuration
- Macro `CHANGE_DISP_TIMEOUT_EN`.
- Defined:
  - An 8-bit wait counter runs in EJECT and clears on entry to EJECT.
  - If it reaches `ACK_TIMEOUT` without an ack, go to FAULT at that edge and set `fault`.
- Undefined:
  - No wait counter is built; EJECT waits indefinitely.
  - `fault` is tied 0 and FAULT is unreachable.

## Structure
- Shared package `vending_pkg` holds:
  - the state enum;
  - the coin value constants 10/5/2/1;
  - the one-hot eject codes;
  - the 6-bit value width.
- One sub-module, `coin_picker`: combinational priority select from the four counts to a one-hot code plus its unit value.
- The top holds the FSM, counters and timer.

## Test plan
- Reset then `load` with c10=1, c5=0, c2=2, c1=1, ack returned 1 cycle after each eject → eject sequence 1000, 0010, 0010, 0001; `remaining` goes 15→5→3→1→0; one `done` pulse; `busy` low afterwards.
- `load` with all counts 0 → `done` the cycle after load, `eject` never non-zero, `remaining`=0.
- `load` with c10=3, c5=3, c2=3, c1=3, `coin_ack` tied high, `GAP_CYCLES`=2 → 12 ejects each 3 cycles apart; `remaining` starts at 54 and ends at 0.
- Second `load` with c1=3 during dispensing → ignored; the coin count matches the first load only.
- Reset asserted mid-EJECT → `eject`, `busy` and `remaining` go to 0 immediately without waiting for a clock edge; the next `load` works normally.
- With `CHANGE_DISP_TIMEOUT_EN` and `ACK_TIMEOUT`=8, no ack → `fault`=1 on the 8th cycle of EJECT, `eject`=0, `load` ignored until reset.
